memctrl_hw: RTL and testbench

//  Memory-side stage of the instruction cache. Serves the cache's line-fill requests (memory_stb/addr/data/ack).

---
 rtl/memctrl_hw.sv | 145 ++++++++++++++
 tb/tb_memctrl_hw.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/memctrl_hw.sv
// Memory-side fill engine for the instruction cache: builds each 32-bit word from two
// wait-stated 16-bit RAM reads. Optional one-word reuse buffer: define MEMCTRL_LASTWORD_EN.
module memctrl_hw #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_stb,
    input  logic [13:0] memory_addr,
    output logic [31:0] memory_data,
    output logic        memory_ack,
    output logic        ram_rd,
    output logic [14:0] ram_addr,
    input  logic [15:0] ram_data
);

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI,
        RD_LO,
        ACK,
        GAP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [13:0] addr_buf;
    logic        accept;
    logic        hi_done;
    logic        lo_done;
    logic        cnt_dec;

`ifdef MEMCTRL_LASTWORD_EN
    logic        lw_valid;
    logic [13:0] lw_addr;
    logic [31:0] lw_data;
    logic        lw_hit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // RAM strobes and ack decode only from registered state, so ack never sees stb combinationally.
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        hi_done    = 1'b0;
        lo_done    = 1'b0;
        cnt_dec    = 1'b0;
        ram_rd     = 1'b0;
        ram_addr   = '0;
        memory_ack = 1'b0;
`ifdef MEMCTRL_LASTWORD_EN
        lw_hit     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (memory_stb) begin
`ifdef MEMCTRL_LASTWORD_EN
                    if (lw_valid && (memory_addr == lw_addr)) begin
                        lw_hit  = 1'b1;
                        state_n = ACK;
                    end else begin
                        accept  = 1'b1;
                        state_n = RD_HI;
                    end
`else
                    accept  = 1'b1;
                    state_n = RD_HI;
`endif
                end
            end
            RD_HI: begin
                ram_rd   = 1'b1;
                ram_addr = {addr_buf, 1'b0};
                if (cnt == 4'd0) begin
                    hi_done = 1'b1;
                    state_n = RD_LO;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_LO: begin
                ram_rd   = 1'b1;
                ram_addr = {addr_buf, 1'b1};
                if (cnt == 4'd0) begin
                    lo_done = 1'b1;
                    state_n = ACK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                memory_ack = 1'b1;
                state_n    = GAP;
            end
            // The cache keeps stb up through the ack cycle and one more; this cycle absorbs that.
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            addr_buf    <= '0;
            memory_data <= '0;
        end else begin
            if (accept) begin
                addr_buf <= memory_addr;
                cnt      <= CNT_INIT;
            end else if (hi_done) begin
                memory_data[31:16] <= ram_data;
                cnt                <= CNT_INIT;
            end else if (lo_done) begin
                memory_data[15:0] <= ram_data;
            end else if (cnt_dec) begin
                cnt <= cnt - 4'd1;
            end
`ifdef MEMCTRL_LASTWORD_EN
            if (lw_hit) memory_data <= lw_data;
`endif
        end
    end

`ifdef MEMCTRL_LASTWORD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lw_valid <= 1'b0;
            lw_addr  <= '0;
            lw_data  <= '0;
        end else if (lo_done) begin
            lw_valid <= 1'b1;
            lw_addr  <= addr_buf;
            lw_data  <= {memory_data[31:16], ram_data};
        end
    end
`endif

endmodule

// File: tb/tb_memctrl_hw.sv
// Directed bench for memctrl_hw: one instance at RD_LAT=2, one at RD_LAT=1, RAM returns ~address.
// Expected words and latencies are queued at request time and checked when ack arrives.
module tb_memctrl_hw;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb   [2];
    logic [13:0] addr  [2];
    logic [31:0] mdata [2];
    logic        ack   [2];
    logic        rd    [2];
    logic [14:0] raddr [2];
    logic [15:0] rdata [2];

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int last_ack = 0;
    int prev_ack = 0;

    logic [31:0] sb_q  [$];
    int          lat_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign rdata[0] = ~{1'b0, raddr[0]};
    assign rdata[1] = ~{1'b0, raddr[1]};

    memctrl_hw #(.RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .memory_stb(stb[0]), .memory_addr(addr[0]),
        .memory_data(mdata[0]), .memory_ack(ack[0]), .ram_rd(rd[0]),
        .ram_addr(raddr[0]), .ram_data(rdata[0])
    );

    memctrl_hw #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .memory_stb(stb[1]), .memory_addr(addr[1]),
        .memory_data(mdata[1]), .memory_ack(ack[1]), .ram_rd(rd[1]),
        .ram_addr(raddr[1]), .ram_data(rdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_word(input logic [13:0] a);
        logic [15:0] h;
        logic [15:0] l;
        h = ~{1'b0, a, 1'b0};
        l = ~{1'b0, a, 1'b1};
        return {h, l};
    endfunction

    // k counts edges from the accepting one; ack is expected visible just after edge exp_lat.
    task automatic fill(input int s, input logic [13:0] a, input int exp_lat, input int exp_rd,
                        input bit drop, input string tag);
        int k, hi, lo, bad, el;
        logic [14:0] ha, la;
        logic [31:0] ew;
        ha = {a, 1'b0};
        la = {a, 1'b1};
        @(negedge clk);
        stb[s]  = 1'b1;
        addr[s] = a;
        sb_q.push_back(exp_word(a));
        lat_q.push_back(exp_lat);
        k = 0; hi = 0; lo = 0; bad = 0;
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (drop && k == 1) begin
                stb[s]  = 1'b0;
                addr[s] = ~a;
            end
            if (rd[s]) begin
                if (raddr[s] == ha)      hi++;
                else if (raddr[s] == la) lo++;
                else                     bad++;
            end
            if (ack[s]) break;
        end
        chk({tag, "_ack_seen"}, 32'(ack[s]), 32'd1);
        prev_ack = last_ack;
        last_ack = cyc;
        if (sb_q.size() > 0) begin
            ew = sb_q.pop_front();
            el = lat_q.pop_front();
            chk({tag, "_latency"}, k, el);
            chk({tag, "_data"}, mdata[s], ew);
        end
        chk({tag, "_hi_cycles"}, hi, exp_rd);
        chk({tag, "_lo_cycles"}, lo, exp_rd);
        chk({tag, "_stray_rd"}, bad, 0);
        @(posedge clk); #1;
        chk({tag, "_gap_ack"}, 32'(ack[s]), 32'd0);
        chk({tag, "_gap_rd"}, 32'(rd[s]), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_idle_ack"}, 32'(ack[s]), 32'd0);
        chk({tag, "_idle_rd"}, 32'(rd[s]), 32'd0);
        stb[s] = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_after_rd"}, 32'(rd[s]), 32'd0);
        chk({tag, "_after_ack"}, 32'(ack[s]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stb[i]  = 1'b0;
            addr[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ack", 32'(ack[i]), 32'd0);
            chk("reset_rd", 32'(rd[i]), 32'd0);
            chk("reset_raddr", 32'(raddr[i]), 32'd0);
            chk("reset_data", mdata[i], 32'd0);
        end
        rst = 1'b0;

        // single fill, stb held through ack+1
        fill(0, 14'h0123, 5, 2, 1'b0, "single");
        chk("single_word", mdata[0], 32'hFDB9FDB8);

        // back-to-back fills
        fill(0, 14'h0001, 5, 2, 1'b0, "b2b_a");
        fill(0, 14'h3FFF, 5, 2, 1'b0, "b2b_b");
        chk("b2b_word", mdata[0], 32'h80018000);
        chk("b2b_spacing", 32'(last_ack - prev_ack >= 7), 32'd1);

        // async reset while in RD_LO
        @(negedge clk);
        stb[0]  = 1'b1;
        addr[0] = 14'h0055;
        repeat (3) @(posedge clk);
        #1;
        chk("prerst_rd", 32'(rd[0]), 32'd1);
        chk("prerst_raddr", 32'(raddr[0]), 32'h000AB);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack[0]), 32'd0);
        chk("rst_rd", 32'(rd[0]), 32'd0);
        chk("rst_raddr", 32'(raddr[0]), 32'd0);
        chk("rst_data", mdata[0], 32'd0);
        stb[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_idle_rd", 32'(rd[0]), 32'd0);
        fill(0, 14'h1234, 5, 2, 1'b0, "postrst");

        // stb and addr dropped mid-fill: fill still completes on the latched address
        fill(0, 14'h0BCD, 5, 2, 1'b1, "drop");

        // RD_LAT=1 instance
        fill(1, 14'h2AAA, 3, 1, 1'b0, "lat1");
        chk("lat1_word", mdata[1], 32'hAAABAAAA);

`ifdef MEMCTRL_LASTWORD_EN
        fill(0, 14'h0010, 5, 2, 1'b0, "lw_miss");
        fill(0, 14'h0010, 1, 0, 1'b0, "lw_hit");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fill(0, 14'h0010, 5, 2, 1'b0, "lw_after_rst");
`else
        fill(0, 14'h0010, 5, 2, 1'b0, "rep_a");
        fill(0, 14'h0010, 5, 2, 1'b0, "rep_b");
`endif

        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
